// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular FIFO between imem and decode.
// FETCH_BUFFER_BYPASS_EN enables a zero-latency path when the FIFO is empty.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ihit,
  input  logic [31:0]              imemload,
  input  logic [31:0]              imemaddr,
  input  logic                     flush,
  input  logic                     dec_ready,
  output logic                     dec_valid,
  output logic [31:0]              dec_instr,
  output logic [31:0]              dec_pc,
  output logic [31:0]              dec_npc,
  output logic                     fetch_stall,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   instr_d [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   pc_d    [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic byp;
  logic push;
  logic pop;

  assign full  = (count_q == FULL);
  assign empty = (count_q == '0);

`ifdef FETCH_BUFFER_BYPASS_EN
  assign byp = empty && ihit && !flush;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    dec_valid = !empty && !flush;
    dec_instr = instr_q[rd_ptr_q];
    dec_pc    = pc_q[rd_ptr_q];
`ifdef FETCH_BUFFER_BYPASS_EN
    if (byp) begin
      dec_valid = 1'b1;
      dec_instr = imemload;
      dec_pc    = imemaddr;
    end
`endif
  end

  assign dec_npc     = dec_pc + 32'd4;
  assign fetch_stall = full;
  assign count       = count_q;

  // A bypassed word consumed by decode never enters the FIFO.
  assign push = ihit && !flush && !full && !(byp && dec_ready);
  assign pop  = dec_valid && dec_ready && !flush && !byp;

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = imemload;
        pc_d[wr_ptr_q]    = imemaddr;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer against a queue-based model.
// Honours FETCH_BUFFER_BYPASS_EN in the model when defined.
module tb_fetch_buffer;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic [31:0] imemaddr;
  logic        flush;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_npc;
  logic        fetch_stall;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemaddr(imemaddr), .flush(flush), .dec_ready(dec_ready),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_npc(dec_npc), .fetch_stall(fetch_stall), .count(count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic bit m_byp();
`ifdef FETCH_BUFFER_BYPASS_EN
    return (mq.size() == 0) && ihit && !flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_valid();
    return m_byp() || ((mq.size() != 0) && !flush);
  endfunction

  function automatic logic [31:0] exp_instr();
    if (m_byp()) return imemload;
    if (mq.size() == 0) return 32'h0;
    return mq[0][63:32];
  endfunction

  function automatic logic [31:0] exp_pc();
    if (m_byp()) return imemaddr;
    if (mq.size() == 0) return 32'h0;
    return mq[0][31:0];
  endfunction

  task automatic drive(input logic ih, input logic [31:0] ld,
                       input logic [31:0] ad, input logic fl,
                       input logic rd);
    ihit      = ih;
    imemload  = ld;
    imemaddr  = ad;
    flush     = fl;
    dec_ready = rd;
    #1;
  endtask

  // Apply the spec's push/pop/flush/reset rules to the model, then clock.
  task automatic advance();
    int n;
    bit byp;
    bit pu;
    bit po;
    n   = mq.size();
    byp = m_byp();
    if (RST || flush) begin
      mq.delete();
    end else begin
      po = (n != 0) && dec_ready && !byp;
      pu = ihit && (n < DEPTH) && !(byp && dec_ready);
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back({imemload, imemaddr});
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0);
    advance();
    drive(0, 32'h0, 32'h0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dec_valid !== 1'b0) begin
        errors++; $display("FAIL reset_valid[%0d] got %0b exp 0", k, dec_valid);
      end
      checks++;
      if (fetch_stall !== 1'b0) begin
        errors++; $display("FAIL reset_stall[%0d] got %0b exp 0", k, fetch_stall);
      end
      checks++;
      if (count !== 3'd0) begin
        errors++; $display("FAIL reset_count[%0d] got %0d exp 0", k, count);
      end
      checks++;
      if (dec_instr !== 32'h0 || dec_pc !== 32'h0) begin
        errors++;
        $display("FAIL reset_head[%0d] got %h/%h exp 0/0", k, dec_instr, dec_pc);
      end
      checks++;
      if (dec_npc !== 32'h4) begin
        errors++; $display("FAIL reset_npc[%0d] got %h exp 4", k, dec_npc);
      end
      advance();
      RST = 1'b0;
      drive(0, 32'h0, 32'h0, 0, 1);
    end
  endtask

  task automatic test_single();
    drive(1, 32'h8C220004, 32'h0, 0, 1);
    advance();
    drive(0, 32'h0, 32'h0, 0, 1);
    checks++;
    if (dec_valid !== exp_valid()) begin
      errors++; $display("FAIL single_valid got %0b exp %0b", dec_valid, exp_valid());
    end
    if (exp_valid()) begin
      checks++;
      if (dec_instr !== 32'h8C220004 || dec_pc !== 32'h0 || dec_npc !== 32'h4) begin
        errors++;
        $display("FAIL single_word got %h/%h/%h exp 8c220004/0/4",
                 dec_instr, dec_pc, dec_npc);
      end
    end
    advance();
    drive(0, 32'h0, 32'h0, 0, 0);
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL single_count got %0d exp 0", count);
    end
  endtask

  task automatic test_full();
    logic [31:0] exp_seq [3];
    exp_seq = '{32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 5; i++) begin
      drive(1, $urandom, 32'(i * 4), 0, 0);
      advance();
      drive(0, 32'h0, 32'h0, 0, 0);
      checks++;
      if (count !== 3'((i < 4) ? i + 1 : 4)) begin
        errors++; $display("FAIL full_count[%0d] got %0d", i, count);
      end
      checks++;
      if (fetch_stall !== (i >= 3)) begin
        errors++; $display("FAIL full_stall[%0d] got %0b exp %0b", i, fetch_stall, i >= 3);
      end
    end
    drive(1, $urandom, 32'h20, 0, 1);
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
      errors++; $display("FAIL full_pop_head got %0b/%h exp 1/0", dec_valid, dec_pc);
    end
    advance();
    drive(0, 32'h0, 32'h0, 0, 1);
    checks++;
    if (count !== 3'd3 || fetch_stall !== 1'b0) begin
      errors++; $display("FAIL full_pop_push got %0d/%0b exp 3/0", count, fetch_stall);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== exp_seq[i]) begin
        errors++;
        $display("FAIL drain[%0d] got %0b/%h exp 1/%h", i, dec_valid, dec_pc, exp_seq[i]);
      end
      advance();
      drive(0, 32'h0, 32'h0, 0, 1);
    end
    checks++;
    if (count !== 3'd0 || dec_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty got %0d/%0b exp 0/0", count, dec_valid);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, 32'h200 + 32'(i * 4), 0, 0);
      advance();
    end
    drive(1, $urandom, 32'h300, 1, 1);
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL flush_pre_count got %0d exp 3", count);
    end
    checks++;
    if (dec_valid !== 1'b0) begin
      errors++; $display("FAIL flush_valid_during got %0b exp 0", dec_valid);
    end
    advance();
    drive(0, 32'h0, 32'h0, 0, 0);
    checks++;
    if (count !== 3'd0 || dec_valid !== 1'b0) begin
      errors++; $display("FAIL flush_after got %0d/%0b exp 0/0", count, dec_valid);
    end
  endtask

  task automatic test_wrap();
    drive(1, $urandom, 32'hFFFF_FFFC, 0, 0);
    advance();
    drive(0, 32'h0, 32'h0, 0, 0);
    checks++;
    if (dec_pc !== 32'hFFFF_FFFC || dec_npc !== 32'h0) begin
      errors++; $display("FAIL wrap_npc got %h/%h exp fffffffc/0", dec_pc, dec_npc);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, $urandom, 32'h100 + 32'(i * 4), 0, 1'(i % 2));
      checks++;
      if (dec_valid !== exp_valid() || (exp_valid() && dec_pc !== exp_pc())) begin
        errors++;
        $display("FAIL wrap_mix[%0d] got %0b/%h exp %0b/%h",
                 i, dec_valid, dec_pc, exp_valid(), exp_pc());
      end
      advance();
    end
    for (int i = 0; i < 8 && mq.size() != 0; i++) begin
      drive(0, 32'h0, 32'h0, 0, 1);
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== exp_pc() || dec_instr !== exp_instr()) begin
        errors++;
        $display("FAIL wrap_drain[%0d] got %h/%h exp %h/%h",
                 i, dec_pc, dec_instr, exp_pc(), exp_instr());
      end
      advance();
    end
  endtask

  task automatic test_latency();
    drive(1, 32'h1234_5678, 32'h40, 0, 1);
    checks++;
`ifdef FETCH_BUFFER_BYPASS_EN
    if (dec_valid !== 1'b1 || dec_pc !== 32'h40) begin
      errors++; $display("FAIL lat_same got %0b/%h exp 1/40", dec_valid, dec_pc);
    end
`else
    if (dec_valid !== 1'b0) begin
      errors++; $display("FAIL lat_same got %0b exp 0", dec_valid);
    end
`endif
    advance();
    drive(0, 32'h0, 32'h0, 0, 1);
    checks++;
`ifdef FETCH_BUFFER_BYPASS_EN
    if (dec_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL lat_next got %0b/%0d exp 0/0", dec_valid, count);
    end
`else
    if (dec_valid !== 1'b1 || dec_pc !== 32'h40 || dec_instr !== 32'h1234_5678) begin
      errors++; $display("FAIL lat_next got %0b/%h exp 1/40", dec_valid, dec_pc);
    end
`endif
    advance();
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 2; i++) begin
      drive(1, $urandom, 32'h500 + 32'(i * 4), 0, 0);
      advance();
    end
    RST = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 1);
    advance();
    RST = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 1);
    checks++;
    if (count !== 3'd0 || dec_valid !== 1'b0 || dec_pc !== 32'h0) begin
      errors++;
      $display("FAIL midreset got %0d/%0b/%h exp 0/0/0", count, dec_valid, dec_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    pc = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      RST = ($urandom % 60 == 0);
      drive(1'($urandom % 4 != 0), $urandom, pc,
            1'($urandom % 16 == 0), 1'($urandom % 3 != 0));
      checks++;
      if (dec_valid !== exp_valid()) begin
        errors++; $display("FAIL rnd_valid[%0d] got %0b exp %0b", c, dec_valid, exp_valid());
      end
      checks++;
      if (count !== 3'(mq.size()) || fetch_stall !== (mq.size() == DEPTH)) begin
        errors++;
        $display("FAIL rnd_count[%0d] got %0d/%0b exp %0d", c, count, fetch_stall, mq.size());
      end
      checks++;
      if (exp_valid()) begin
        if (dec_instr !== exp_instr() || dec_pc !== exp_pc() ||
            dec_npc !== exp_pc() + 32'd4) begin
          errors++;
          $display("FAIL rnd_head[%0d] got %h/%h/%h exp %h/%h", c,
                   dec_instr, dec_pc, dec_npc, exp_instr(), exp_pc());
        end
      end else if ($isunknown({dec_instr, dec_pc, dec_npc})) begin
        errors++; $display("FAIL rnd_x[%0d] got %h/%h exp known", c, dec_instr, dec_pc);
      end
      if (ihit && (mq.size() < DEPTH)) pc = pc + 32'd4;
      advance();
    end
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    ihit = 1'b0;
    imemload = '0;
    imemaddr = '0;
    flush = 1'b0;
    dec_ready = 1'b0;
    @(negedge CLK);
    test_reset();
    test_single();
    test_full();
    test_flush();
    test_wrap();
    test_latency();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
